// File: rtl/switch_reader.sv
// Slide-switch input stage: two-flop synchronizer, tick-based debounce per channel,
// and a single-entry event register fed from a pending-change vector (lowest index first).
module switch_reader #(
  parameter int TICK_WIDTH   = 16,
  parameter int STABLE_COUNT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_sw,
  output logic [15:0] o_state,
  output logic        o_evt_valid,
  input  logic        i_evt_ready,
  output logic [3:0]  o_evt_index,
  output logic        o_evt_level,
  output logic        o_overflow
);

  localparam logic [2:0] CNT_LAST = 3'(STABLE_COUNT - 1);

  logic [TICK_WIDTH-1:0] r_presc;
  logic [15:0]           r_sync1;
  logic [15:0]           r_sync2;
  logic [15:0]           r_pending;
  logic [2:0]            r_cnt [16];

  logic                  w_tick;
  logic [15:0]           w_flip;
  logic [15:0]           w_clr;
  logic [2:0]            w_cnt_next [16];
  logic                  w_free;
  logic                  w_load;
  logic [3:0]            w_sel;

  assign w_tick = &r_presc;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 16; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (w_tick) begin
        if (r_sync2[i] == o_state[i]) begin
          w_cnt_next[i] = '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          w_flip[i]     = 1'b1;
          w_cnt_next[i] = '0;
        end else begin
          w_cnt_next[i] = r_cnt[i] + 3'd1;
        end
      end
    end
  end

  // Descending scan so the lowest set index is the one that sticks.
  always_comb begin
    w_sel = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_pending[i]) w_sel = 4'(i);
    end
    w_free = !o_evt_valid || i_evt_ready;
    w_load = w_free && (r_pending != '0);
    w_clr  = w_load ? (16'b1 << w_sel) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc     <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      o_state     <= '0;
      r_pending   <= '0;
      o_evt_valid <= 1'b0;
      o_evt_index <= '0;
      o_evt_level <= 1'b0;
      o_overflow  <= 1'b0;
      // NOTE: the counter array is small flop storage, not RAM, so it is reset like any register.
      for (int i = 0; i < 16; i++) r_cnt[i] <= '0;
    end else begin
      r_presc   <= r_presc + 1'b1;
      r_sync1   <= i_sw;
      r_sync2   <= r_sync1;
      o_state   <= o_state ^ w_flip;
      r_pending <= (r_pending & ~w_clr) | w_flip;
      for (int i = 0; i < 16; i++) r_cnt[i] <= w_cnt_next[i];
      // A fresh change on a channel whose previous change is still queued is lost.
      if ((w_flip & r_pending & ~w_clr) != '0) o_overflow <= 1'b1;
      if (w_free) o_evt_valid <= (r_pending != '0);
      if (w_load) begin
        o_evt_index <= w_sel;
        o_evt_level <= o_state[w_sel];
      end
    end
  end

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader (TICK_WIDTH=2, STABLE_COUNT=3) with a cycle model
// checked every cycle plus hand-computed literal expectations.
module tb_switch_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw = '0;
  logic        ready = 1'b0;
  logic [15:0] state;
  logic        evt_valid;
  logic [3:0]  evt_index;
  logic        evt_level;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_vseen  = 0;

  switch_reader #(.TICK_WIDTH(2), .STABLE_COUNT(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_sw(sw), .o_state(state),
    .o_evt_valid(evt_valid), .i_evt_ready(ready), .o_evt_index(evt_index),
    .o_evt_level(evt_level), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: switch history, tick schedule by cycle count, run length of
  // disagreeing ticks per switch, and a set of pending switches served lowest first.
  bit          m_up = 0;
  int          cyc;
  logic [15:0] hist1, hist2, m_state, m_pend;
  int          run [16];
  bit          m_valid, m_lvl, m_ovf;
  int          m_idx;

  always @(posedge clk) begin
    bit          tick, served;
    logic [15:0] changed;
    int          first;
    if (rst) begin
      m_up = 1; cyc = 0; hist1 = '0; hist2 = '0; m_state = '0; m_pend = '0;
      m_valid = 0; m_idx = 0; m_lvl = 0; m_ovf = 0;
      for (int i = 0; i < 16; i++) run[i] = 0;
    end else if (m_up) begin
      if (evt_valid && ready) n_acc++;
      tick = (cyc % 4) == 3;
      changed = '0;
      if (tick) begin
        for (int i = 0; i < 16; i++) begin
          if (hist2[i] != m_state[i]) run[i] = run[i] + 1; else run[i] = 0;
          if (run[i] == 3) begin changed[i] = 1'b1; run[i] = 0; end
        end
      end
      served = 0;
      first = 0;
      if ((!m_valid || ready) && m_pend != 0) begin
        while (!m_pend[first]) first++;
        served = 1;
      end
      if (served) begin
        m_idx = first; m_lvl = m_state[first];
        m_pend[first] = 1'b0;
      end
      if (!m_valid || ready) m_valid = served;
      if ((changed & m_pend) != 0) m_ovf = 1;
      m_pend  = m_pend | changed;
      m_state = m_state ^ changed;
      hist2 = hist1; hist1 = sw;
      cyc++;
    end
    #1;
    if (m_up) begin
      check("state", 32'(state), 32'(m_state));
      check("evt_valid", 32'(evt_valid), 32'(m_valid));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("tick", 32'(dut.w_tick), 32'((cyc % 4) == 3));
      if (m_valid) begin
        check("evt_index", 32'(evt_index), 32'(m_idx));
        check("evt_level", 32'(evt_level), 32'(m_lvl));
      end
      if (evt_valid) n_vseen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_acc = 0;
    n_vseen = 0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!evt_valid && k < budget) begin step(1); k++; end
    check("wait_valid", 32'(evt_valid), 32'd1);
  endtask

  initial begin
    step(2);

    // Single switch held through reset; tick cadence and exact debounce latency.
    sw = 16'h0001; ready = 1'b1;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      check("tick_cadence", 32'(dut.w_tick), 32'((k % 4) == 3));
      if (k == 11) check("state_before_flip", 32'(state), 32'h0);
      if (k == 12) check("state_after_flip", 32'(state), 32'h1);
      if (k == 13) begin
        check("evt1_valid", 32'(evt_valid), 32'd1);
        check("evt1_index", 32'(evt_index), 32'd0);
        check("evt1_level", 32'(evt_level), 32'd1);
      end
      if (k == 14) check("evt1_dropped", 32'(evt_valid), 32'd0);
      if (k < 16) step(1);
    end
    step(4);
    check("evt1_count", 32'(n_acc), 32'd1);
    check("evt1_vcycles", 32'(n_vseen), 32'd1);
    check("evt1_ovf", 32'(overflow), 32'd0);

    // Bouncing switch never settles for three consecutive ticks.
    sw = '0; ready = 1'b1;
    do_reset();
    for (int t = 0; t < 10; t++) begin
      sw[5] = ~sw[5];
      step(4);
    end
    sw = '0;
    step(20);
    check("bounce_state", 32'(state), 32'h0);
    check("bounce_vcycles", 32'(n_vseen), 32'd0);

    // Two simultaneous rises, consumer stalled, then single-cycle accepts.
    sw = '0; ready = 1'b0;
    do_reset();
    sw = 16'h0208;
    wait_valid(40);
    check("pair_first_index", 32'(evt_index), 32'd3);
    check("pair_first_level", 32'(evt_level), 32'd1);
    step(5);
    check("pair_hold_valid", 32'(evt_valid), 32'd1);
    check("pair_hold_index", 32'(evt_index), 32'd3);
    ready = 1'b1; step(1); ready = 1'b0;
    check("pair_second_valid", 32'(evt_valid), 32'd1);
    check("pair_second_index", 32'(evt_index), 32'd9);
    check("pair_second_level", 32'(evt_level), 32'd1);
    step(3);
    ready = 1'b1; step(1); ready = 1'b0;
    check("pair_drained", 32'(evt_valid), 32'd0);

    // Rise/fall/rise on one switch with the consumer stalled: overflow on the third change.
    sw = '0; ready = 1'b0;
    do_reset();
    sw = 16'h0004; step(24);
    check("ovf_evt_index", 32'(evt_index), 32'd2);
    check("ovf_evt_level", 32'(evt_level), 32'd1);
    sw = 16'h0000; step(24);
    check("ovf_after_fall", 32'(overflow), 32'd0);
    check("ovf_state_low", 32'(state), 32'h0);
    sw = 16'h0004; step(24);
    check("ovf_after_rise", 32'(overflow), 32'd1);
    ready = 1'b1; step(1); ready = 1'b0;
    check("ovf_next_valid", 32'(evt_valid), 32'd1);
    check("ovf_next_index", 32'(evt_index), 32'd2);
    check("ovf_next_level", 32'(evt_level), 32'd1);

    // Reset mid-count with an event outstanding; the held switches re-debounce afterwards.
    sw = 16'h0084;
    step(6);
    do_reset();
    check("rst_state", 32'(state), 32'h0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    ready = 1'b1;
    step(30);
    check("rst_reevents", 32'(n_acc), 32'd2);
    check("rst_restate", 32'(state), 32'h0084);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
